// File: rtl/instr_mem_pkg.sv
// Shared constants and FSM state encoding for the instruction memory loader.
package instr_mem_pkg;

  localparam int unsigned InstrWidth     = 16;
  localparam int unsigned ByteWidth      = 8;
  localparam int unsigned DefaultMemSize = 16;

  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StLenHi = 3'd1;
  localparam state_t StLenLo = 3'd2;
  localparam state_t StData  = 3'd3;
  localparam state_t StCsum  = 3'd4;
  localparam state_t StDone  = 3'd5;
  localparam state_t StErr   = 3'd6;

endpackage

// File: rtl/instr_mem_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory and
// holds the core until a good image is present.
module instr_mem_loader
  import instr_mem_pkg::*;
#(
  parameter int unsigned N  = DefaultMemSize,
  parameter int unsigned AW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [ByteWidth-1:0] in_data,
  output logic                 in_ready,
  output logic                 wr_en,
  output logic [AW-1:0]        wr_addr,
  output logic [ByteWidth-1:0] wr_data,
  output logic                 core_hold,
  output logic                 done,
  output logic                 error
);

  localparam logic [15:0] MaxLen = 16'(N);

  state_t               state_q, state_d;
  logic [ByteWidth-1:0] len_hi_q, len_hi_d;
  logic [15:0]          rem_q, rem_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [ByteWidth-1:0] acc_q, acc_d;
  logic                 wr_en_q, wr_en_d;
  logic [AW-1:0]        wr_addr_q, wr_addr_d;
  logic [ByteWidth-1:0] wr_data_q, wr_data_d;

  logic        xfer;
  logic [15:0] len;

  assign in_ready  = (state_q == StLenHi) || (state_q == StLenLo) ||
                     (state_q == StData)  || (state_q == StCsum);
  assign core_hold = (state_q != StDone);
  assign done      = (state_q == StDone);
  assign error     = (state_q == StErr);

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

  assign xfer = in_valid && in_ready;
  assign len  = {len_hi_q, in_data};

  always_comb begin
    state_d   = state_q;
    len_hi_d  = len_hi_q;
    rem_d     = rem_q;
    addr_d    = addr_q;
    acc_d     = acc_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d = StLenHi;
          acc_d   = '0;
        end
      end
      StLenHi: begin
        if (xfer) begin
          len_hi_d = in_data;
          state_d  = StLenLo;
        end
      end
      StLenLo: begin
        if (xfer) begin
          if (len[0] || (len > MaxLen)) begin
            state_d = StErr;
          end else if (len == 16'd0) begin
            state_d = StCsum;
          end else begin
            state_d = StData;
            rem_d   = len;
            addr_d  = '0;
            acc_d   = '0;
          end
        end
      end
      StData: begin
        if (xfer) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = in_data;
          acc_d     = acc_q ^ in_data;
          rem_d     = rem_q - 16'd1;
          // Hold the address on the final byte so it never reaches N.
          if (rem_q == 16'd1) begin
            state_d = StCsum;
          end else begin
            addr_d = addr_q + AW'(1);
          end
        end
      end
      StCsum: begin
        if (xfer) begin
          state_d = (in_data == acc_q) ? StDone : StErr;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      len_hi_q  <= '0;
      rem_q     <= '0;
      addr_q    <= '0;
      acc_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      len_hi_q  <= len_hi_d;
      rem_q     <= rem_d;
      addr_q    <= addr_d;
      acc_q     <= acc_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: driver pushes expected writes, monitor pops them.
module tb_instr_mem_loader;

  localparam int unsigned N  = 16;
  localparam int unsigned AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          core_hold;
  logic          done;
  logic          error;

  instr_mem_loader #(.N(N), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .core_hold (core_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
    int            cyc;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;
  bit  tog    = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    tog <= ~tog;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write, in the expected cycle.
  always @(negedge clk) begin
    wr_t e;
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
        chk("wr_data", 32'(wr_data), 32'(e.data));
        chk("wr_cycle", cyc, e.cyc);
      end
    end
  end

  // Reference: 1 = good image, 2 = rejected. send = bytes the loader will consume.
  function automatic int model(input logic [7:0] img[$], output int send);
    int         l;
    logic [7:0] x;
    l = int'({img[0], img[1]});
    if ((l % 2) != 0 || l > int'(N)) begin
      send = 2;
      return 2;
    end
    send = l + 3;
    x = 8'h00;
    for (int i = 0; i < l; i++) x = x ^ img[2 + i];
    return (img[l + 2] == x) ? 1 : 2;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_wr_en"}, 32'(wr_en), 0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
    chk({tag, "_wr_data"}, 32'(wr_data), 0);
    chk({tag, "_core_hold"}, 32'(core_hold), 1);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_error"}, 32'(error), 0);
  endtask

  // Pulse start (with a junk byte offered that must not be taken), then stream `limit`
  // bytes of img. mode: 0 continuous, 1 random valid and random start, 2 alternating valid.
  task automatic stream(input logic [7:0] img[$], input int mode, input int limit,
                        output int start_cyc, output bit ok);
    int l;
    int waitc;
    bit acc;
    l  = int'({img[0], img[1]});
    ok = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    chk("ready_at_start", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    start     = 1'b0;
    start_cyc = cyc;
    for (int i = 0; i < limit; i++) begin
      in_data = img[i];
      waitc   = 0;
      do begin
        case (mode)
          1: begin
            in_valid = 1'($urandom_range(0, 1));
            start    = 1'($urandom_range(0, 1));
          end
          2:       in_valid = tog;
          default: in_valid = 1'b1;
        endcase
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
        waitc++;
      end while (!acc && waitc < 50);
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL byte_timeout: got no transfer expected byte %0d accepted", i);
        ok = 1'b0;
        break;
      end
      if (i >= 2 && i < l + 2) exp_q.push_back('{addr: AW'(i - 2), data: img[i], cyc: cyc});
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic load(input string tag, input logic [7:0] img[$], input int mode);
    int outcome;
    int send;
    int start_cyc;
    bit ok;
    outcome = model(img, send);
    stream(img, mode, send, start_cyc, ok);
    if (!ok) return;
    if (mode == 0) chk({tag, "_latency"}, cyc - start_cyc, send);
    chk({tag, "_done"}, 32'(done), 32'(outcome == 1));
    chk({tag, "_error"}, 32'(error), 32'(outcome == 2));
    chk({tag, "_core_hold"}, 32'(core_hold), 32'(outcome != 1));
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_sticky"}, 32'({done, error}), outcome == 1 ? 32'h2 : 32'h1);
    chk({tag, "_writes_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    logic [7:0] good[$];
    logic [7:0] img[$];
    int         l;
    int         start_cyc;
    bit         ok;

    good = '{8'h00, 8'h08, 8'h10, 8'h10, 8'h60, 8'h02, 8'hD0, 8'h04, 8'h10, 8'h11, 8'hB7};
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    load("good", good, 0);

    img = good;
    img[10] = 8'h00;
    load("bad_csum", img, 0);
    load("reload_good", good, 0);

    img = '{8'h00, 8'h11};
    load("len_too_big", img, 0);
    img = '{8'h00, 8'h03};
    load("len_odd", img, 0);

    load("bp_alt", good, 2);
    load("bp_rand", good, 1);

    img = '{8'h00, 8'h00, 8'h00};
    load("empty_good", img, 0);
    img = '{8'h00, 8'h00, 8'h01};
    load("empty_bad", img, 0);

    for (int t = 0; t < 8; t++) begin
      logic [7:0] x;
      l = 2 * $urandom_range(0, N / 2);
      if ($urandom_range(0, 5) == 0) l = l + 1;
      img = '{8'(l >> 8), 8'(l)};
      x = 8'h00;
      for (int i = 0; i < l; i++) begin
        img.push_back(8'($urandom));
        x = x ^ img[i + 2];
      end
      if ($urandom_range(0, 3) == 0) x = x ^ 8'(1 << $urandom_range(0, 7));
      img.push_back(x);
      load("random", img, $urandom_range(0, 1));
    end

    // Reset after three payload bytes; the third write is seen before reset lands.
    stream(good, 1, 5, start_cyc, ok);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    chk("mid_reset_writes", exp_q.size(), 0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("post_reset_idle_ready", 32'(in_ready), 0);
    chk("post_reset_hold", 32'(core_hold), 1);
    load("after_reset", good, 0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
